// File: rtl/data_mem_sized_if.sv
// MEM-stage bus between the CPU datapath and data_mem_sized.
// Request fields flow master->slave; DB/ready/err flow back.
interface data_mem_sized_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic        DBSrc;
  logic [31:0] result;
  logic [31:0] B_data;
  logic [31:0] DB;
  logic        ready;
  logic        err;

  modport master (
    output req, we, size, sign_ext,
    output DBSrc, result, B_data,
    input  DB, ready, err
  );

  modport slave (
    input  req, we, size, sign_ext,
    input  DBSrc, result, B_data,
    output DB, ready, err
  );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory with req/ready handshake.
// Ports: CLK, Rst (async low), bus (slave), watch (nibble taps).
module data_mem_sized #(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 0,
  parameter int WATCH_N     = 4
) (
  input  logic                 CLK,
  input  logic                 Rst,
  data_mem_sized_if.slave      bus,
  output logic [4*WATCH_N-1:0] watch
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] LP_CNT0 =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sx;
  logic        r_src;
  logic [31:0] r_db;
  logic        r_ready;
  logic        r_err;
  logic [7:0]  r_mem [DEPTH_BYTES];

  logic        w_is_b;
  logic        w_is_h;
  logic        w_is_w;
  logic        w_is_r;
  logic [2:0]  w_nb;
  logic        w_mis;
  logic        w_oor;
  logic        w_err;
  logic [32:0] w_idx   [4];
  logic [7:0]  w_old   [4];
  logic [7:0]  w_wbyte [4];
  logic [7:0]  w_new   [4];
  logic [3:0]  w_wen;
  logic [31:0] w_ld;
  logic [31:0] w_word;
  logic [31:0] w_db_next;

  assign w_is_b = (r_size == 2'b00);
  assign w_is_h = (r_size == 2'b01);
  assign w_is_w = (r_size == 2'b10);
  assign w_is_r = (r_size == 2'b11);

  // Bytes past the end read as zero so a store near the top
  // can still return "the word at A" without indexing out.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = {1'b0, r_addr} + 33'(k);
      w_old[k] = '0;
      if (w_idx[k] < 33'(DEPTH_BYTES))
        w_old[k] = r_mem[w_idx[k][AW-1:0]];
    end
  end

  always_comb begin
    w_nb  = 3'd4;
    w_mis = 1'b0;
    w_ld  = '0;
    for (int k = 0; k < 4; k++)
      w_wbyte[k] = '0;
    unique case (1'b1)
      w_is_b: begin
        w_nb       = 3'd1;
        w_ld       = {{24{r_sx & w_old[0][7]}},
                      w_old[0]};
        w_wbyte[0] = r_wdata[7:0];
      end
      w_is_h: begin
        w_nb       = 3'd2;
        w_mis      = r_addr[0];
        w_ld       = {{16{r_sx & w_old[0][7]}},
                      w_old[0], w_old[1]};
        w_wbyte[0] = r_wdata[15:8];
        w_wbyte[1] = r_wdata[7:0];
      end
      w_is_w: begin
        w_nb  = 3'd4;
        w_mis = |r_addr[1:0];
        w_ld  = {w_old[0], w_old[1],
                 w_old[2], w_old[3]};
        for (int k = 0; k < 4; k++)
          w_wbyte[k] = r_wdata[31-8*k -: 8];
      end
      w_is_r: begin
        w_mis = 1'b1;
      end
      default: ;
    endcase
  end

  // 33-bit sum: a huge address never wraps back into range.
  assign w_oor = ({1'b0, r_addr} + 33'(w_nb)) >
                 33'(DEPTH_BYTES);
  assign w_err = w_mis | w_oor;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_wen[k] = r_we & ~w_err & (3'(k) < w_nb);
      w_new[k] = w_wen[k] ? w_wbyte[k] : w_old[k];
    end
  end

  assign w_word = {w_new[0], w_new[1],
                   w_new[2], w_new[3]};

  always_comb begin
    w_db_next = r_addr;
    if (w_err)
      w_db_next = '0;
    else if (r_src)
      w_db_next = r_we ? w_word : w_ld;
  end

  // Response is registered on the edge leaving RESP, so the
  // cycle with ready=1 is already IDLE and may accept req.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_sx    <= 1'b0;
      r_src   <= 1'b0;
      r_db    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++)
        r_mem[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (bus.req) begin
            r_addr  <= bus.result;
            r_wdata <= bus.B_data;
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sx    <= bus.sign_ext;
            r_src   <= bus.DBSrc;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LP_CNT0;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= S_RESP;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: begin
          for (int k = 0; k < 4; k++)
            if (w_wen[k])
              r_mem[w_idx[k][AW-1:0]] <= w_wbyte[k];
          r_db    <= w_db_next;
          r_ready <= 1'b1;
          r_err   <= w_err;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.DB    = r_db;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;

  for (genvar g = 0; g < WATCH_N; g++) begin : g_watch
    assign watch[4*g +: 4] = r_mem[4*g+3][3:0];
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: WAIT_CYCLES 0 and 2 side by side,
// directed steps then random traffic against a byte model.
module tb_data_mem_sized;

  logic        CLK;
  logic        Rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic        DBSrc;
  logic [31:0] result;
  logic [31:0] B_data;
  logic [15:0] watch0;
  logic [15:0] watch2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m [128];

  data_mem_sized_if if0 ();
  data_mem_sized_if if2 ();

  assign if0.req      = req;
  assign if0.we       = we;
  assign if0.size     = size;
  assign if0.sign_ext = sign_ext;
  assign if0.DBSrc    = DBSrc;
  assign if0.result   = result;
  assign if0.B_data   = B_data;
  assign if2.req      = req;
  assign if2.we       = we;
  assign if2.size     = size;
  assign if2.sign_ext = sign_ext;
  assign if2.DBSrc    = DBSrc;
  assign if2.result   = result;
  assign if2.B_data   = B_data;

  data_mem_sized #(
    .DEPTH_BYTES(128), .WAIT_CYCLES(0), .WATCH_N(4)
  ) u_d0 (
    .CLK(CLK), .Rst(Rst), .bus(if0.slave), .watch(watch0)
  );

  data_mem_sized #(
    .DEPTH_BYTES(128), .WAIT_CYCLES(2), .WATCH_N(4)
  ) u_d2 (
    .CLK(CLK), .Rst(Rst), .bus(if2.slave), .watch(watch2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(int unsigned a);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++)
      v = (v << 8) | ((a + i < 128) ? 32'(m[a+i]) : 32'd0);
    return v;
  endfunction

  function automatic logic [31:0] watch_model();
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = m[4*k+3][3:0];
    return v;
  endfunction

  task automatic model(input logic w, input logic [1:0] sz,
                       input logic sx, input logic src,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output logic e_err,
                       output logic [31:0] e_db);
    longint nb;
    longint v;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    e_err = (sz == 3) || ((longint'(a) % nb) != 0) ||
            (longint'(a) + nb > 128);
    if (e_err) begin
      e_db = 0;
      return;
    end
    if (w)
      for (int i = 0; i < nb; i++)
        m[a+i] = 8'(d >> (8 * (nb - 1 - i)));
    v = 0;
    for (int i = 0; i < nb; i++)
      v = v * 256 + longint'(m[a+i]);
    if (sx && nb < 4 && v >= (longint'(1) << (8*nb-1)))
      v = v - (longint'(1) << (8*nb));
    if (!src)      e_db = a;
    else if (w)    e_db = word_at(a);
    else           e_db = 32'(v);
  endtask

  task automatic xact(input logic w, input logic [1:0] sz,
                      input logic sx, input logic src,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input string tag);
    logic        e_err;
    logic [31:0] e_db;
    logic [31:0] e_wt;
    model(w, sz, sx, src, a, d, e_err, e_db);
    e_wt = watch_model();
    @(negedge CLK);
    we = w; size = sz; sign_ext = sx; DBSrc = src;
    result = a; B_data = d; req = 1'b1;
    @(posedge CLK); #1; req = 1'b0;
    chk({tag, ".rdy0_e0"}, 32'(if0.ready), 0);
    @(posedge CLK); #1;
    chk({tag, ".rdy0"}, 32'(if0.ready), 1);
    chk({tag, ".db0"}, if0.DB, e_db);
    chk({tag, ".err0"}, 32'(if0.err), 32'(e_err));
    chk({tag, ".wt0"}, 32'(watch0), e_wt);
    chk({tag, ".rdy2_e1"}, 32'(if2.ready), 0);
    @(posedge CLK); #1;
    chk({tag, ".rdy0_e2"}, 32'(if0.ready), 0);
    chk({tag, ".rdy2_e2"}, 32'(if2.ready), 0);
    @(posedge CLK); #1;
    chk({tag, ".rdy2"}, 32'(if2.ready), 1);
    chk({tag, ".db2"}, if2.DB, e_db);
    chk({tag, ".err2"}, 32'(if2.err), 32'(e_err));
    chk({tag, ".wt2"}, 32'(watch2), e_wt);
    @(posedge CLK); #1;
    chk({tag, ".rdy2_e4"}, 32'(if2.ready), 0);
  endtask

  initial begin
    logic        rw, rsx, rsrc;
    logic [1:0]  rsz;
    logic [31:0] ra;
    int          sel, nb;

    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    Rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00;
    sign_ext = 1'b0; DBSrc = 1'b0;
    result = '0; B_data = '0;
    #12;
    chk("rst.db0", if0.DB, 0);
    chk("rst.db2", if2.DB, 0);
    chk("rst.rdy", {if0.ready, if2.ready}, 0);
    chk("rst.err", {if0.err, if2.err}, 0);
    chk("rst.wt", {watch0, watch2}, 0);
    @(negedge CLK); Rst = 1'b1;

    // reset aborting an in-flight store
    xact(1, 2'b10, 0, 1, 32'h40, 32'hCAFEF00D, "pre_sw");
    xact(1, 2'b00, 0, 0, 32'h7, 32'h5, "pre_sb");
    @(negedge CLK);
    we = 1; size = 2'b10; DBSrc = 1;
    result = 32'h44; B_data = 32'hA5A5A5A5; req = 1;
    @(posedge CLK); #1; req = 0; Rst = 0;
    #1;
    chk("abort.db", {if0.DB, if2.DB}, 0);
    chk("abort.rdy", {if0.ready, if2.ready}, 0);
    chk("abort.wt", {watch0, watch2}, 0);
    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    @(negedge CLK); Rst = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("abort.idle", {if0.ready, if2.ready}, 0);
    xact(0, 2'b10, 0, 1, 32'h44, 0, "abort_lw44");
    xact(0, 2'b10, 0, 1, 32'h40, 0, "abort_lw40");

    // word round trip and big-endian byte order
    xact(1, 2'b10, 0, 1, 32'h10, 32'h12345678, "sw10");
    xact(0, 2'b10, 0, 1, 32'h10, 0, "lw10");
    for (int i = 0; i < 4; i++)
      xact(0, 2'b00, 0, 1, 32'h10 + i, 0, "lbu1x");

    // sub-word and extension
    xact(1, 2'b00, 0, 1, 32'h21, 32'h80, "sb21");
    xact(0, 2'b00, 1, 1, 32'h21, 0, "lb21");
    xact(0, 2'b00, 0, 1, 32'h21, 0, "lbu21");
    xact(1, 2'b01, 0, 1, 32'h22, 32'hBEEF, "sh22");
    xact(0, 2'b01, 1, 1, 32'h22, 0, "lh22");
    xact(0, 2'b01, 0, 1, 32'h22, 0, "lhu22");

    // error cases
    xact(0, 2'b10, 0, 1, 32'h11, 0, "lw11_mis");
    xact(1, 2'b01, 0, 1, 32'h03, 32'h1234, "sh03_mis");
    xact(0, 2'b10, 0, 1, 32'h00, 0, "lw00_after");
    xact(0, 2'b10, 0, 1, 32'h7C, 0, "lw7C_ok");
    xact(0, 2'b10, 0, 1, 32'h80, 0, "lw80_oor");
    xact(0, 2'b11, 0, 1, 32'h08, 0, "rsvd");
    xact(1, 2'b01, 0, 1, 32'h7E, 32'h9A9B, "sh7E_top");
    xact(1, 2'b00, 0, 0, 32'hFFFFFFFF, 1, "sb_huge");

    // passthrough and watch
    xact(0, 2'b10, 0, 0, 32'h3C, 0, "pass3C");
    xact(1, 2'b00, 0, 0, 32'h7, 32'h0A, "sb07");

    // req held high: accept rate is WAIT_CYCLES+2
    @(negedge CLK);
    we = 0; size = 2'b10; DBSrc = 1;
    result = 32'h10; req = 1;
    for (int e = 0; e < 8; e++) begin
      @(posedge CLK); #1;
      chk($sformatf("held.rdy2_e%0d", e), 32'(if2.ready),
          32'((e == 3) || (e == 7)));
      chk($sformatf("held.rdy0_e%0d", e), 32'(if0.ready),
          32'(e % 2));
    end
    req = 0;
    chk("held.db2", if2.DB, 32'h12345678);
    @(posedge CLK); #1;
    chk("held.end", {if0.ready, if2.ready}, 0);

    // random traffic
    for (int it = 0; it < 80; it++) begin
      rw   = 1'($urandom_range(0, 1));
      rsx  = 1'($urandom_range(0, 1));
      rsrc = 1'($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 9);
      rsz  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 :
             (sel < 9) ? 2'b10 : 2'b11;
      nb   = (rsz == 0) ? 1 : (rsz == 1) ? 2 : 4;
      if ($urandom_range(0, 9) == 0)
        ra = $urandom_range(120, 140);
      else
        ra = $urandom_range(0, 127);
      if ($urandom_range(0, 4) != 0)
        ra = ra - (ra % nb);
      xact(rw, rsz, rsx, rsrc, ra, $urandom,
           $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
